// File: rtl/conv_scheduler_pkg.sv
// Shared definitions for the convolution job scheduler: FSM encoding and the
// default result latency of the shared convolution unit.
package conv_scheduler_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  // One multiply-accumulate per window element plus two cycles of pipeline slack.
  function automatic int lat_default(input int d, input int f);
    return d * f * f + 2;
  endfunction

endpackage

// File: rtl/conv_scheduler_rr_arbiter.sv
// Round-robin arbiter: one-hot grant among N_REQ requests, priority rotating to
// the index after the last granted one whenever advance is pulsed.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDW   = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic             advance,
  output logic [N_REQ-1:0] grant,
  output logic [IDW-1:0]   grant_idx
);

  logic [IDW-1:0] ptr;
  logic [IDW-1:0] idx;
  logic           found;
  int             j;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    j         = 0;
    for (int i = 0; i < N_REQ; i++) begin
      j = int'(ptr) + i;
      if (j >= N_REQ) j = j - N_REQ;
      idx = IDW'(j);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (grant_idx == IDW'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/conv_scheduler.sv
// Time-shares one external convolution unit among N_REQ requesters: grant,
// clear the unit, wait LAT cycles, hold the result until the consumer takes it.
module conv_scheduler
  import conv_scheduler_pkg::*;
#(
  parameter  int DATA_WIDTH = 8,
  parameter  int D          = 1,
  parameter  int F          = 3,
  parameter  int N_REQ      = 4,
  parameter  int LAT        = lat_default(D, F),
  localparam int IDW        = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  localparam int WIN        = D * F * F * DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [N_REQ*WIN-1:0]  req_image,
  input  logic [N_REQ*WIN-1:0]  req_filter,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [DATA_WIDTH-1:0] rsp_result,
  output logic                  cu_reset,
  output logic [WIN-1:0]        cu_image,
  output logic [WIN-1:0]        cu_filter,
  input  logic [DATA_WIDTH-1:0] cu_result
);

  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

  state_t                state, next_state;
  logic [N_REQ-1:0]      grant;
  logic [IDW-1:0]        grant_idx;
  logic                  grant_fire;
  logic [CW-1:0]         cnt;
  logic                  last_cycle;
  logic [IDW-1:0]        id_q;
  logic [WIN-1:0]        img_q, flt_q;
  logic [WIN-1:0]        sel_img, sel_flt;
  logic [DATA_WIDTH-1:0] result_q;
  logic                  cu_reset_q;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDW   (IDW)
  ) u_arb (
    .clk       (clk),
    .reset     (reset),
    .req       (req_valid),
    .advance   (grant_fire),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // Requests are only looked at in IDLE, and never while reset is held.
  assign grant_fire = reset && (state == IDLE) && (|req_valid);
  assign req_ready  = grant_fire ? grant : '0;
  assign last_cycle = (cnt == CW'(LAT - 1));

  always_comb begin
    sel_img = '0;
    sel_flt = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (grant[k]) begin
        sel_img = req_image[k*WIN +: WIN];
        sel_flt = req_filter[k*WIN +: WIN];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (grant_fire) next_state = CLEAR;
      CLEAR:   next_state = RUN;
      RUN:     if (last_cycle) next_state = DONE;
      DONE:    if (rsp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // cu_reset is registered so the unit stays cleared through reset and the CLEAR cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt        <= '0;
      id_q       <= '0;
      img_q      <= '0;
      flt_q      <= '0;
      result_q   <= '0;
      cu_reset_q <= 1'b1;
    end else begin
      cu_reset_q <= (next_state == CLEAR);
      if (grant_fire) begin
        id_q  <= grant_idx;
        img_q <= sel_img;
        flt_q <= sel_flt;
      end
      if (state == CLEAR)                   cnt <= '0;
      else if (state == RUN && !last_cycle) cnt <= cnt + 1'b1;
      if (state == RUN && last_cycle) result_q <= cu_result;
    end
  end

  assign rsp_valid  = (state == DONE);
  assign rsp_id     = id_q;
  assign rsp_result = result_q;
  assign cu_reset   = cu_reset_q;
  assign cu_image   = img_q;
  assign cu_filter  = flt_q;

endmodule
